clk_div_multi: RTL
==================

Name: clk_div_multi

Overview:
Parametrised multi-channel clock divider / tick generator, the successor to the fixed single-output divider. Each channel has a runtime-programmable divisor, enable, and mode: 50% square-wave toggle or single-cycle tick. Divisor updates are shadowed and applied glitch-free at the next terminal count. A global sync input phase-aligns all channels. Feeds display multiplexing, debouncers and sampling strobes from the board system clock.

Parameters:
NUM_CH, 4, number of independent divider channels (1..16)
CNT_W, 16, counter and divisor width in bits
DEFAULT_DIV, 999, reset value of every channel's active and shadow divisor (must fit CNT_W)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-high; clears all state
en  input  NUM_CH  per-channel enable
mode  input  NUM_CH  per-channel mode: 0 = toggle (square wave), 1 = tick (pulse)
load  input  NUM_CH  per-channel one-cycle strobe capturing div_in slice into the shadow divisor
div_in  input  NUM_CH*CNT_W  packed divisors; channel i = bits [i*CNT_W +: CNT_W]
sync  input  1  synchronous phase-align strobe for all channels
clkout  output  NUM_CH  toggle-mode square wave; held 0 in tick mode or when disabled
tick  output  NUM_CH  one-cycle pulse per terminal count, both modes
pending  output  NUM_CH  shadow divisor loaded but not yet active

Behaviour:
- One clock, clk; reset asynchronous, active-high. Reset: cnt=0, clkout=0, tick=0, pending=0, active_div=shadow_div=DEFAULT_DIV for every channel.
- Per channel, registers: cnt[CNT_W], active_div, shadow_div, out, tick, pending. All outputs registered.
- Terminal count: cnt == active_div while en=1 and sync=0. On terminal: cnt<=0; tick<=1 next cycle (one cycle wide); in toggle mode out<=~out.
- Otherwise with en=1: cnt<=cnt+1; tick<=0.
- Period: tick every active_div+1 cycles. Toggle-mode clkout period 2*(active_div+1), duty exactly 50%.
- active_div=0: tick held high continuously; clkout = clk/2.
- en=0: cnt<=0, out<=0, tick<=0; divisor registers and pending retained. On re-enable, counting starts from 0 and the first tick arrives active_div+1 cycles later.
- mode change takes effect next cycle; switching to tick mode forces out<=0; cnt is not reset.
- load: shadow_div<=div_in slice, pending<=1.
  * Channel disabled: active_div<=div_in slice the same edge; pending stays 0.
  * Load coincident with terminal: new value goes straight to active_div for the next period; pending stays 0.
  * Otherwise applied at next terminal (active_div<=shadow_div, pending<=0).
  * Repeated loads before terminal: last value wins.
- sync (priority over en and terminal, below reset): all channels cnt<=0, out<=0, tick<=0. Any pending shadow is applied to active_div immediately and pending cleared.
- cnt never exceeds active_div. If active_div is shrunk below cnt (possible only via sync-less coincident paths), cnt compare uses >= so terminal fires next cycle; no wrap through 2^CNT_W.
- Channels fully independent except for sync.

Decomposition:
- Package clk_div_pkg: typedef mode_e {MODE_TOGGLE=0, MODE_TICK=1}; localparam CNT_W_DEF=16; function div_for_hz(sys_hz, out_hz) returning the toggle-mode divisor (sys_hz/(2*out_hz))-1 for testbench and instantiation use.
- Sub-module clk_div_ch: one channel (counter, shadow logic, outputs), parametrised by CNT_W and DEFAULT_DIV. Instantiated NUM_CH times in a generate loop; top contains only slicing and sync fan-out.

Test Plan:
- Reset default: release reset, en=1 all, mode=0 -> clkout[0] first rises after 1000 cycles, period 2000 cycles, tick every 1000 cycles; pending=0.
- Tick mode, div 4: disabled load div_in=4, en=1, mode=1 -> tick high 1 cycle every 5, clkout stays 0, pending never set.
- Shadowed update: running at div 9, load 3 mid-period -> pending=1 until next terminal; old period of 10 completes, then periods of 4; no short or runt pulse on clkout.
- Coincident load and terminal, plus div=0: load 0 on terminal edge -> pending=0, following period uses 0: tick constant 1, clkout toggles every cycle.
- Sync alignment: channels at div 2, 5, 7 free-running with different phases; pulse sync -> all cnt=0, clkout=0, tick=0 next cycle; ticks coincide at cycle 24 (LCM of 3, 6, 8).
- Async reset mid-operation: assert reset between clock edges while pending=1 -> outputs 0 immediately without a clk edge; active_div and shadow_div back to 999; pending cleared.

Source files
------------

// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the multi-channel clock divider.
// Used by the RTL and by anything that instantiates it (divisor calculation).
package clk_div_pkg;

  typedef enum logic {
    MODE_TOGGLE = 1'b0,
    MODE_TICK   = 1'b1
  } mode_e;

  localparam int CNT_W_DEF = 16;

  // Toggle-mode divisor giving out_hz on clkout from a sys_hz clock.
  function automatic int unsigned div_for_hz(input int unsigned sys_hz,
                                             input int unsigned out_hz);
    if (out_hz == 0 || sys_hz < 2 * out_hz) return 0;
    return (sys_hz / (2 * out_hz)) - 1;
  endfunction

endpackage

// File: rtl/clk_div_ch.sv
// One divider channel: counter, shadowed divisor and registered clkout/tick/pending.
// A new divisor only ever becomes active while the counter restarts from zero.
module clk_div_ch
  import clk_div_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int DEFAULT_DIV = 999
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en_i,
  input  logic             mode_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] div_i,
  input  logic             sync_i,
  output logic             clkout_o,
  output logic             tick_o,
  output logic             pending_o
);

  localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);

  if (DEFAULT_DIV < 0 || (longint'(DEFAULT_DIV) >> CNT_W) != 0) begin : gen_bad_default
    $error("clk_div_ch: DEFAULT_DIV does not fit in CNT_W bits");
  end

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] active_q, active_d;
  logic [CNT_W-1:0] shadow_q, shadow_d;
  logic             out_q, out_d;
  logic             tick_q, tick_d;
  logic             pending_q, pending_d;

  logic terminal;
  logic tick_mode;

  // >= rather than == so a counter left above a shrunk divisor never wraps.
  assign terminal  = (cnt_q >= active_q);
  assign tick_mode = (mode_e'(mode_i) == MODE_TICK);

  always_comb begin
    cnt_d     = cnt_q;
    active_d  = active_q;
    shadow_d  = shadow_q;
    out_d     = out_q;
    tick_d    = 1'b0;
    pending_d = pending_q;

    if (load_i) shadow_d = div_i;

    if (sync_i) begin
      cnt_d     = '0;
      out_d     = 1'b0;
      pending_d = 1'b0;
      if (load_i)         active_d = div_i;
      else if (pending_q) active_d = shadow_q;
    end else if (!en_i) begin
      cnt_d = '0;
      out_d = 1'b0;
      if (load_i) begin
        active_d  = div_i;
        pending_d = 1'b0;
      end
    end else if (terminal) begin
      cnt_d     = '0;
      tick_d    = 1'b1;
      out_d     = tick_mode ? 1'b0 : ~out_q;
      pending_d = 1'b0;
      if (load_i)         active_d = div_i;
      else if (pending_q) active_d = shadow_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
      out_d = tick_mode ? 1'b0 : out_q;
      if (load_i) pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q     <= '0;
      active_q  <= DIV_RST;
      shadow_q  <= DIV_RST;
      out_q     <= 1'b0;
      tick_q    <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      active_q  <= active_d;
      shadow_q  <= shadow_d;
      out_q     <= out_d;
      tick_q    <= tick_d;
      pending_q <= pending_d;
    end
  end

  assign clkout_o  = out_q;
  assign tick_o    = tick_q;
  assign pending_o = pending_q;

  a_cnt_bounded: assert property (@(posedge clk) disable iff (reset) cnt_q <= active_q);

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel clock divider / tick generator: NUM_CH independent channels
// sharing one phase-align strobe.
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = CNT_W_DEF,
  parameter int DEFAULT_DIV = 999
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CH-1:0]       en,
  input  logic [NUM_CH-1:0]       mode,
  input  logic [NUM_CH-1:0]       load,
  input  logic [NUM_CH*CNT_W-1:0] div_in,
  input  logic                    sync,
  output logic [NUM_CH-1:0]       clkout,
  output logic [NUM_CH-1:0]       tick,
  output logic [NUM_CH-1:0]       pending
);

  if (NUM_CH < 1 || NUM_CH > 16) begin : gen_bad_num_ch
    $error("clk_div_multi: NUM_CH must be 1..16");
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : gen_ch
    clk_div_ch #(
      .CNT_W      (CNT_W),
      .DEFAULT_DIV(DEFAULT_DIV)
    ) u_ch (
      .clk      (clk),
      .reset    (reset),
      .en_i     (en[i]),
      .mode_i   (mode[i]),
      .load_i   (load[i]),
      .div_i    (div_in[i*CNT_W +: CNT_W]),
      .sync_i   (sync),
      .clkout_o (clkout[i]),
      .tick_o   (tick[i]),
      .pending_o(pending[i])
    );
  end

endmodule
